// File: rtl/alu_pipe_if.sv
// alu_pipe_if: handshake bundle for the alu_pipe block.
// The input channel carries operands and opcode with in_valid/in_ready.
// The output channel carries the result and flag set with out_valid/out_ready.
// The master modport is the producer/consumer side (decode stage plus write-back).
// The slave modport is the ALU side.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [2:0]       alu_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero_flag;
   logic             carry_flag;
   logic             negative_flag;
   logic             overflow_flag;

   modport master (
      output in_valid, operand_a, operand_b, alu_op, out_ready,
      input  in_ready, out_valid, result,
      input  zero_flag, carry_flag, negative_flag, overflow_flag
   );

   modport slave (
      input  in_valid, operand_a, operand_b, alu_op, out_ready,
      output in_ready, out_valid, result,
      output zero_flag, carry_flag, negative_flag, overflow_flag
   );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered ALU with a zero/carry/negative/overflow flag set.
// Non-multiply ops are computed combinationally and registered on accept.
//
// Optional feature macro ALU_PIPE_MUL_EN:
// - Defined: op 111 runs a WIDTH-cycle shift-add multiply on a small IDLE/MUL state machine.
// - Undefined: the multiply is absent, and op 111 completes in one cycle with result 0.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_pipe_if.slave  bus
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   // Shift amounts at or above this value flush the operand completely.
   localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH[WIDTH-1:0];

   logic             accept_s;
   logic             out_free_s;
   logic             idle_s;
   logic             is_mul_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_carry_s;
   logic             alu_ovf_s;
   logic             load_mul_s;
   logic [WIDTH-1:0] mul_res_s;
   logic             mul_carry_s;

   logic [WIDTH-1:0] result_r;
   logic             zero_r;
   logic             carry_r;
   logic             negative_r;
   logic             overflow_r;
   logic             out_valid_r;

   // The output slot is free when it is empty or drained on this edge.
   // in_ready deliberately ignores in_valid.
   assign out_free_s   = !out_valid_r || bus.out_ready;
   assign bus.in_ready = idle_s && out_free_s && rst_n;
   assign accept_s     = bus.in_valid && bus.in_ready;

`ifdef ALU_PIPE_MUL_EN
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   localparam int              CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t             state_r;
   state_t             state_n_s;
   logic [2*WIDTH-1:0] mcand_r;
   logic [2*WIDTH-1:0] prod_r;
   logic [2*WIDTH-1:0] prod_n_s;
   logic [WIDTH-1:0]   mplier_r;
   logic [CNT_W-1:0]   step_r;

   assign idle_s      = (state_r == IDLE);
   assign is_mul_s    = (bus.alu_op == OP_MUL);
   assign load_mul_s  = (state_r == MUL) && (step_r == LAST_STEP);
   assign mul_res_s   = prod_n_s[WIDTH-1:0];
   assign mul_carry_s = |prod_n_s[2*WIDTH-1:WIDTH];

   // Accumulate the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      prod_n_s = prod_r;
      if (mplier_r[0]) begin
         prod_n_s = prod_r + mcand_r;
      end else begin
         prod_n_s = prod_r;
      end
   end

   // Multiply sequencer state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // IDLE leaves only on an accepted multiply. MUL returns after the final partial-product step.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && is_mul_s) begin
               state_n_s = MUL;
            end else begin
               state_n_s = IDLE;
            end
         end
         MUL: begin
            if (load_mul_s) begin
               state_n_s = IDLE;
            end else begin
               state_n_s = MUL;
            end
         end
         default: state_n_s = IDLE;
      endcase
   end

   // Shift-add datapath: one multiplier bit consumed per cycle. A reset abandons the operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_r  <= {(2*WIDTH){1'b0}};
         prod_r   <= {(2*WIDTH){1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         step_r   <= {CNT_W{1'b0}};
      end else if (accept_s && is_mul_s) begin
         mcand_r  <= {{WIDTH{1'b0}}, bus.operand_a};
         prod_r   <= {(2*WIDTH){1'b0}};
         mplier_r <= bus.operand_b;
         step_r   <= {CNT_W{1'b0}};
      end else if (state_r == MUL) begin
         mcand_r  <= mcand_r << 1'b1;
         prod_r   <= prod_n_s;
         mplier_r <= mplier_r >> 1'b1;
         step_r   <= step_r + CNT_W'(1);
      end
   end
`else
   assign idle_s      = 1'b1;
   assign is_mul_s    = 1'b0;
   assign load_mul_s  = 1'b0;
   assign mul_res_s   = {WIDTH{1'b0}};
   assign mul_carry_s = 1'b0;
`endif

   // Single-cycle ALU.
   // Add and sub are computed one bit wider so the top bit is the carry (add) or borrow (sub).
   always_comb begin
      sum_s       = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
      diff_s      = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
      alu_res_s   = {WIDTH{1'b0}};
      alu_carry_s = 1'b0;
      alu_ovf_s   = 1'b0;
      case (bus.alu_op)
         OP_ADD: begin
            alu_res_s   = sum_s[WIDTH-1:0];
            alu_carry_s = sum_s[WIDTH];
            alu_ovf_s   = (bus.operand_a[WIDTH-1] == bus.operand_b[WIDTH-1]) &&
                          (sum_s[WIDTH-1] != bus.operand_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res_s   = diff_s[WIDTH-1:0];
            alu_carry_s = diff_s[WIDTH];
            alu_ovf_s   = (bus.operand_a[WIDTH-1] != bus.operand_b[WIDTH-1]) &&
                          (diff_s[WIDTH-1] != bus.operand_a[WIDTH-1]);
         end
         OP_AND: alu_res_s = bus.operand_a & bus.operand_b;
         OP_OR:  alu_res_s = bus.operand_a | bus.operand_b;
         OP_XOR: alu_res_s = bus.operand_a ^ bus.operand_b;
         OP_SHL: begin
            if (bus.operand_b >= SHIFT_LIMIT) begin
               alu_res_s = {WIDTH{1'b0}};
            end else begin
               alu_res_s = bus.operand_a << bus.operand_b;
            end
         end
         OP_SHR: begin
            if (bus.operand_b >= SHIFT_LIMIT) begin
               alu_res_s = {WIDTH{1'b0}};
            end else begin
               alu_res_s = bus.operand_a >> bus.operand_b;
            end
         end
         // The single-cycle path yields 0 here. With the multiplier built, the product comes from the MUL sequence instead.
         OP_MUL:  alu_res_s = {WIDTH{1'b0}};
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // Output register: loads on a single-cycle accept or the final multiply step.
   // Otherwise it holds, and out_valid drops once the consumer takes the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_r    <= {WIDTH{1'b0}};
         zero_r      <= 1'b0;
         carry_r     <= 1'b0;
         negative_r  <= 1'b0;
         overflow_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (accept_s && !is_mul_s) begin
         result_r    <= alu_res_s;
         zero_r      <= (alu_res_s == {WIDTH{1'b0}});
         carry_r     <= alu_carry_s;
         negative_r  <= alu_res_s[WIDTH-1];
         overflow_r  <= alu_ovf_s;
         out_valid_r <= 1'b1;
      end else if (load_mul_s) begin
         result_r    <= mul_res_s;
         zero_r      <= (mul_res_s == {WIDTH{1'b0}});
         carry_r     <= mul_carry_s;
         negative_r  <= mul_res_s[WIDTH-1];
         overflow_r  <= 1'b0;
         out_valid_r <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign bus.out_valid     = out_valid_r;
   assign bus.result        = result_r;
   assign bus.zero_flag     = zero_r;
   assign bus.carry_flag    = carry_r;
   assign bus.negative_flag = negative_r;
   assign bus.overflow_flag = overflow_r;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's 8-bit combinational ALU. Accepts one operation per cycle on a valid/ready input channel, registers the result and a full flag set (zero, carry, negative, overflow), and presents them on a valid/ready output channel. Sits between the decode/register-read stage and write-back in the simple-ISA CPU. An optional multi-cycle multiply runs on a small internal state machine.

## Interface
Parameters:
- WIDTH, 8, operand and result width; legal range is 4 and above.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  an operation is presented
- in_ready  output  1  block accepts the operation this cycle
- operand_a  input  WIDTH  first operand
- operand_b  input  WIDTH  second operand; also the shift amount
- alu_op  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr (logical), 111 mul
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  registered result
- zero_flag  output  1  result == 0
- carry_flag  output  1  add: carry out; sub: borrow (a < b unsigned); mul: product high half non-zero; otherwise 0
- negative_flag  output  1  result[WIDTH-1]
- overflow_flag  output  1  add/sub: signed overflow; otherwise 0

## Operation
- Accept occurs when in_valid && in_ready on a rising edge.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && rst_n. It has no combinational dependence on in_valid.
- States:
  - IDLE: non-mul ops compute combinationally and load the output registers on accept. out_valid is set to 1.
  - MUL: entered on accept of op 111. Shift-add multiply runs for WIDTH cycles, one partial-product step per cycle. On the last step the block loads the output registers, sets out_valid, and returns to IDLE.
- Output registers hold stable while out_valid && !out_ready.
- out_valid clears on the out_ready edge unless a new accept loads it in the same cycle.
- Arithmetic:
  - add and sub use WIDTH+1-bit internal sums. result is the low WIDTH bits.
  - overflow_flag: add sets it when the operand signs are equal and the result sign differs; sub sets it when the operand signs differ and the result sign differs from a.
  - Shifts use all of operand_b. An amount >= WIDTH gives result 0.
  - mul returns the low WIDTH bits of the unsigned 2·WIDTH product.
- Reset: out_valid=0, result=0, all flags=0, state=IDLE, in_ready=0 while rst_n is low.
- Reset during MUL abandons the operation and no result is produced.

## Timing
- Non-mul latency: accept at edge N gives out_valid=1 after edge N.
- Non-mul throughput is 1 op/cycle while out_ready is held high.
- Mul latency: accept at edge N gives out_valid=1 after edge N+WIDTH. in_ready stays 0 throughout MUL.
- Output-side back-pressure stalls input acceptance in the same cycle. No data is dropped or duplicated.
- The first accept is possible on the first edge with rst_n high, given that in_ready was 1 before that edge.

## Configuration
- ALU_PIPE_MUL_EN defined: op 111 is the multi-cycle multiply described above, and the MUL state exists.
- ALU_PIPE_MUL_EN undefined: the MUL state and multiplier datapath are removed. Op 111 completes in 1 cycle like other ops with result=0, zero_flag=1 and all other flags 0.

## Test plan
All scenarios use WIDTH=8.
- add 0xFF+0x01, out_ready=1 -> one cycle later out_valid=1, result=0x00, zero=1, carry=1, overflow=0, negative=0.
- sub 0x80-0x01 -> result=0x7F, overflow=1, carry=0, negative=0. Then sub 0x01-0x02 -> 0xFF, carry=1, negative=1.
- Back-pressure: hold out_ready=0 for 3 cycles after a result while in_valid stays high with a second op -> in_ready=0 and result/flags stable. Raise out_ready -> the second result appears next cycle. Then stream 4 ops with out_ready=1 -> 4 results on 4 consecutive cycles.
- shl 0x81 by 1 -> 0x02. shr 0x81 by 9 -> 0x00 with zero=1. xor 0xAA^0xAA -> 0x00 with zero=1, carry=0.
- With ALU_PIPE_MUL_EN: mul 0x10*0x11 -> out_valid exactly 8 cycles after accept, result=0x10, carry=1, in_ready=0 throughout. Without the macro: result=0x00, zero=1, 1-cycle latency.
- Pull rst_n low 3 cycles into a MUL, then release -> out_valid=0, result=0, and in_ready=1 on the first cycle after release. A subsequent add 0x02+0x03 returns 0x05.
